vic_irq_arbiter: RTL and testbench

Multi-source interrupt front end for vic_ctrl. It latches edge-triggered requests from N_SRC peripherals into a pending register and applies the per-source enable mask and 2-bit priority. It selects one winner at a time and presents that winner's ISR vector address with a one-cycle IRQ pulse, matching vic_ctrl's i_IRQ/i_ISR_addr inputs. It then tracks the in-service source until vic_ctrl's reti returns it to arbitration; there is no nesting.

---
 rtl/vic_irq_arbiter.sv | 164 ++++++++++++++++
 tb/tb_vic_irq_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vic_irq_arbiter.sv
// vic_irq_arbiter: edge-triggered interrupt front end for vic_ctrl.
// Latches rising edges of the source lines into a pending register and masks
// them with a per-source enable and a global enable. One winner at a time is
// picked by 2-bit priority (3 highest, ties to the lowest index). The winner's
// vector goes out with a one-cycle IRQ pulse, and the source is held in
// service until reti. There is no nesting.
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-low reset
//   i_irq_src    peripheral request lines (rising-edge triggered)
//   i_reti       return-from-interrupt pulse
//   i_cfg_we     config write strobe
//   i_cfg_addr   config register select
//   i_cfg_wdata  config write data
//   o_IRQ        one-cycle request pulse to vic_ctrl
//   o_ISR_addr   vector of the last issued winner
//   o_inserv     a source is in service
//   o_inserv_id  index of the in-service or last-issued source
//   o_pending    pending register (status)
module vic_irq_arbiter #(
  parameter int unsigned N_SRC  = 8,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SRC-1:0]  i_irq_src,
  input  logic              i_reti,
  input  logic              i_cfg_we,
  input  logic [4:0]        i_cfg_addr,
  input  logic [31:0]       i_cfg_wdata,
  output logic              o_IRQ,
  output logic [ADDR_W-1:0] o_ISR_addr,
  output logic              o_inserv,
  output logic [3:0]        o_inserv_id,
  output logic [N_SRC-1:0]  o_pending
);

  localparam int unsigned ID_W   = 4;
  localparam int unsigned PRIO_W = 2 * N_SRC;
  localparam logic [4:0]  A_MASK = 5'h10;
  localparam logic [4:0]  A_PRIO = 5'h11;
  localparam logic [4:0]  A_W1C  = 5'h12;
  localparam logic [4:0]  A_GEN  = 5'h13;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_INSERV = 2'd2
  } state_t;

  state_t              state;
  logic [N_SRC-1:0]    src_q;
  logic [N_SRC-1:0]    pending;
  logic [N_SRC-1:0]    mask;
  logic [PRIO_W-1:0]   prio;
  logic                gen;
  logic [ADDR_W-1:0]   vec [N_SRC];

  logic [N_SRC-1:0]    set_bits;
  logic [N_SRC-1:0]    clr_bits;
  logic [N_SRC-1:0]    eligible;
  logic [N_SRC-1:0]    pending_nxt;
  logic                win_found;
  logic [1:0]          win_prio;
  logic [ID_W-1:0]     win_id;
  logic [ADDR_W-1:0]   win_vec;
  logic [N_SRC-1:0]    win_oh;

  // Not every write-data bit is used for narrow configurations.
  logic unused_wdata;
  assign unused_wdata = ^i_cfg_wdata;

  // Arbitration and next pending value; a new edge always beats any clear.
  always_comb begin
    set_bits  = i_irq_src & ~src_q;
    eligible  = pending & mask & {N_SRC{gen}};
    win_found = 1'b0;
    win_prio  = 2'd0;
    win_id    = '0;
    win_vec   = '0;
    win_oh    = '0;
    // Strictly-greater compare keeps the lowest index on priority ties.
    for (int i = 0; i < N_SRC; i++) begin
      if (eligible[i] && (!win_found || (prio[2*i +: 2] > win_prio))) begin
        win_found = 1'b1;
        win_prio  = prio[2*i +: 2];
        win_id    = ID_W'(i);
        win_vec   = vec[i];
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
    clr_bits = '0;
    if (i_cfg_we && (i_cfg_addr == A_W1C)) begin
      clr_bits = i_cfg_wdata[N_SRC-1:0];
    end
    if ((state == S_IDLE) && win_found) begin
      clr_bits = clr_bits | win_oh;
    end
    pending_nxt = (pending & ~clr_bits) | set_bits;
  end

  // Config registers, pending state and the issue/service FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      src_q       <= '0;
      pending     <= '0;
      mask        <= '0;
      prio        <= '0;
      gen         <= 1'b0;
      o_IRQ       <= 1'b0;
      o_ISR_addr  <= '0;
      o_inserv    <= 1'b0;
      o_inserv_id <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        vec[i] <= '0;
      end
    end else begin
      src_q   <= i_irq_src;
      pending <= pending_nxt;

      if (i_cfg_we) begin
        for (int i = 0; i < N_SRC; i++) begin
          if (i_cfg_addr == 5'(i)) begin
            vec[i] <= i_cfg_wdata[ADDR_W-1:0];
          end
        end
        case (i_cfg_addr)
          A_MASK:  mask <= i_cfg_wdata[N_SRC-1:0];
          A_PRIO:  prio <= i_cfg_wdata[PRIO_W-1:0];
          A_GEN:   gen  <= i_cfg_wdata[0];
          default: ;
        endcase
      end

      case (state)
        S_IDLE: begin
          if (win_found) begin
            o_IRQ       <= 1'b1;
            o_ISR_addr  <= win_vec;
            o_inserv_id <= win_id;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          o_IRQ    <= 1'b0;
          o_inserv <= 1'b1;
          state    <= S_INSERV;
        end
        S_INSERV: begin
          if (i_reti) begin
            o_inserv <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_pending = pending;

endmodule

// File: tb/tb_vic_irq_arbiter.sv
// Self-checking bench for vic_irq_arbiter: a per-cycle vector table, directed
// multi-cycle sequences and a randomized run, all compared against a
// behavioural model of the interrupt rules.
module tb_vic_irq_arbiter;
  localparam int unsigned N  = 8;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  src;
  logic          reti;
  logic          cfg_we;
  logic [4:0]    cfg_addr;
  logic [31:0]   cfg_wdata;
  logic          o_IRQ;
  logic [AW-1:0] o_ISR_addr;
  logic          o_inserv;
  logic [3:0]    o_inserv_id;
  logic [N-1:0]  o_pending;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vic_irq_arbiter #(.N_SRC(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .i_irq_src(src), .i_reti(reti),
    .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr), .i_cfg_wdata(cfg_wdata),
    .o_IRQ(o_IRQ), .o_ISR_addr(o_ISR_addr), .o_inserv(o_inserv),
    .o_inserv_id(o_inserv_id), .o_pending(o_pending)
  );

  // Reference model: request set, configuration and service phase
  // (0 = waiting for a request, 1 = just announced, 2 = being serviced).
  logic          m_irq, m_inserv;
  logic [3:0]    m_id;
  logic [31:0]   m_addr;
  logic [N-1:0]  m_pend, m_prev, m_mask;
  logic          m_gen;
  int            m_phase;
  int            m_prio [N];
  logic [31:0]   m_vec  [N];

  // Highest priority among eligible requests, then lowest index at that level.
  function automatic int pick();
    int top;
    top = -1;
    for (int i = 0; i < N; i++)
      if (m_pend[i] && m_mask[i] && m_gen && m_prio[i] > top) top = m_prio[i];
    if (top < 0) return -1;
    for (int i = 0; i < N; i++)
      if (m_pend[i] && m_mask[i] && m_gen && m_prio[i] == top) return i;
    return -1;
  endfunction

  task automatic model_step();
    int w;
    logic [N-1:0] rise;
    if (!rst) begin
      m_irq = 1'b0; m_inserv = 1'b0; m_id = 4'd0; m_addr = 32'd0;
      m_pend = '0; m_prev = '0; m_mask = '0; m_gen = 1'b0; m_phase = 0;
      for (int i = 0; i < N; i++) begin m_prio[i] = 0; m_vec[i] = 32'd0; end
    end else begin
      rise = src & ~m_prev;
      w = (m_phase == 0) ? pick() : -1;
      case (m_phase)
        0: if (w >= 0) begin
             m_irq = 1'b1; m_addr = m_vec[w]; m_id = 4'(w);
             m_pend[w] = 1'b0; m_phase = 1;
           end
        1: begin m_irq = 1'b0; m_inserv = 1'b1; m_phase = 2; end
        default: if (reti) begin m_inserv = 1'b0; m_phase = 0; end
      endcase
      if (cfg_we && cfg_addr == 5'h12) m_pend = m_pend & ~cfg_wdata[N-1:0];
      m_pend = m_pend | rise;
      if (cfg_we) begin
        if (cfg_addr < 5'd8) m_vec[cfg_addr[2:0]] = cfg_wdata;
        else if (cfg_addr == 5'h10) m_mask = cfg_wdata[N-1:0];
        else if (cfg_addr == 5'h11) begin
          for (int i = 0; i < N; i++) m_prio[i] = int'(cfg_wdata[2*i +: 2]);
        end
        else if (cfg_addr == 5'h13) m_gen = cfg_wdata[0];
      end
      m_prev = src;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Advance one clock, step the model, then compare every output.
  task automatic tick(input string name);
    @(posedge clk);
    model_step();
    #1;
    n_tests++;
    if ({o_IRQ, o_inserv, o_inserv_id, o_pending, o_ISR_addr} !==
        {m_irq, m_inserv, m_id, m_pend, m_addr}) begin
      n_fail++;
      $display("FAIL %s model: got irq=%b inserv=%b id=%0d pend=%h isr=%h required irq=%b inserv=%b id=%0d pend=%h isr=%h at %0t",
               name, o_IRQ, o_inserv, o_inserv_id, o_pending, o_ISR_addr,
               m_irq, m_inserv, m_id, m_pend, m_addr, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [N-1:0] s, input logic rt,
                       input logic we, input logic [4:0] a, input logic [31:0] d);
    rst = r; src = s; reti = rt; cfg_we = we; cfg_addr = a; cfg_wdata = d;
  endtask

  task automatic idle_in();
    drive(1'b1, 8'h00, 1'b0, 1'b0, 5'h00, 32'h0);
  endtask

  task automatic do_reset();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 5'h00, 32'h0);
    tick("reset");
    idle_in();
  endtask

  task automatic cfg(input logic [4:0] a, input logic [31:0] d);
    drive(1'b1, 8'h00, 1'b0, 1'b1, a, d);
    tick("cfg");
    idle_in();
  endtask

  task automatic pulse(input logic [N-1:0] s);
    src = s;
    tick("pulse");
    src = 8'h00;
  endtask

  task automatic wait_irq(input string name, input int budget, input logic [3:0] exp_id);
    int k = 0;
    while (o_IRQ !== 1'b1 && k < budget) begin tick(name); k++; end
    chk(name, 64'({o_IRQ, o_inserv_id}), 64'({1'b1, exp_id}));
  endtask

  task automatic serve(input string name);
    int k = 0;
    while (o_inserv !== 1'b1 && k < 4) begin tick(name); k++; end
    chk({name, "_inserv"}, 64'(o_inserv), 64'd1);
    reti = 1'b1;
    tick(name);
    reti = 1'b0;
    chk({name, "_reti"}, 64'(o_inserv), 64'd0);
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] src;
    logic         reti;
    logic         we;
    logic [4:0]   addr;
    logic [31:0]  wdata;
    logic         irq;
    logic         inserv;
    logic [3:0]   id;
    logic [N-1:0] pend;
    logic [31:0]  isr;
  } vec_t;

  vec_t tbl [25];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int sel;

    // rst, src, reti, we, addr, wdata | irq, inserv, id, pending, isr
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'h00, 32'h0,         1'b0, 1'b0, 4'd0, 8'h00, 32'h0};
    tbl[1]  = '{1'b1, 8'h00, 1'b0, 1'b1, 5'h02, 32'h1111_1111, 1'b0, 1'b0, 4'd0, 8'h00, 32'h0};
    tbl[2]  = '{1'b1, 8'h00, 1'b0, 1'b1, 5'h10, 32'h04,        1'b0, 1'b0, 4'd0, 8'h00, 32'h0};
    tbl[3]  = '{1'b1, 8'h00, 1'b0, 1'b1, 5'h13, 32'h1,         1'b0, 1'b0, 4'd0, 8'h00, 32'h0};
    tbl[4]  = '{1'b1, 8'h04, 1'b0, 1'b0, 5'h00, 32'h0,         1'b0, 1'b0, 4'd0, 8'h04, 32'h0};
    tbl[5]  = '{1'b1, 8'h00, 1'b0, 1'b0, 5'h00, 32'h0,         1'b1, 1'b0, 4'd2, 8'h00, 32'h1111_1111};
    tbl[6]  = '{1'b1, 8'h00, 1'b0, 1'b0, 5'h00, 32'h0,         1'b0, 1'b1, 4'd2, 8'h00, 32'h1111_1111};
    tbl[7]  = '{1'b1, 8'h00, 1'b0, 1'b0, 5'h00, 32'h0,         1'b0, 1'b1, 4'd2, 8'h00, 32'h1111_1111};
    tbl[8]  = '{1'b1, 8'h00, 1'b1, 1'b0, 5'h00, 32'h0,         1'b0, 1'b0, 4'd2, 8'h00, 32'h1111_1111};
    tbl[9]  = '{1'b1, 8'h00, 1'b0, 1'b0, 5'h00, 32'h0,         1'b0, 1'b0, 4'd2, 8'h00, 32'h1111_1111};
    tbl[10] = '{1'b1, 8'h00, 1'b0, 1'b1, 5'h10, 32'h0,         1'b0, 1'b0, 4'd2, 8'h00, 32'h1111_1111};
    tbl[11] = '{1'b1, 8'h08, 1'b0, 1'b0, 5'h00, 32'h0,         1'b0, 1'b0, 4'd2, 8'h08, 32'h1111_1111};
    tbl[12] = '{1'b1, 8'h00, 1'b0, 1'b0, 5'h00, 32'h0,         1'b0, 1'b0, 4'd2, 8'h08, 32'h1111_1111};
    tbl[13] = '{1'b1, 8'h00, 1'b0, 1'b1, 5'h10, 32'h08,        1'b0, 1'b0, 4'd2, 8'h08, 32'h1111_1111};
    tbl[14] = '{1'b1, 8'h00, 1'b0, 1'b0, 5'h00, 32'h0,         1'b1, 1'b0, 4'd3, 8'h00, 32'h0};
    tbl[15] = '{1'b1, 8'h00, 1'b0, 1'b0, 5'h00, 32'h0,         1'b0, 1'b1, 4'd3, 8'h00, 32'h0};
    tbl[16] = '{1'b1, 8'h00, 1'b1, 1'b0, 5'h00, 32'h0,         1'b0, 1'b0, 4'd3, 8'h00, 32'h0};
    tbl[17] = '{1'b1, 8'h00, 1'b0, 1'b1, 5'h13, 32'h0,         1'b0, 1'b0, 4'd3, 8'h00, 32'h0};
    tbl[18] = '{1'b1, 8'h08, 1'b0, 1'b0, 5'h00, 32'h0,         1'b0, 1'b0, 4'd3, 8'h08, 32'h0};
    tbl[19] = '{1'b1, 8'h00, 1'b0, 1'b0, 5'h00, 32'h0,         1'b0, 1'b0, 4'd3, 8'h08, 32'h0};
    tbl[20] = '{1'b1, 8'h00, 1'b0, 1'b1, 5'h13, 32'h1,         1'b0, 1'b0, 4'd3, 8'h08, 32'h0};
    tbl[21] = '{1'b1, 8'h00, 1'b0, 1'b0, 5'h00, 32'h0,         1'b1, 1'b0, 4'd3, 8'h00, 32'h0};
    tbl[22] = '{1'b1, 8'h00, 1'b0, 1'b0, 5'h00, 32'h0,         1'b0, 1'b1, 4'd3, 8'h00, 32'h0};
    tbl[23] = '{1'b1, 8'h00, 1'b1, 1'b0, 5'h00, 32'h0,         1'b0, 1'b0, 4'd3, 8'h00, 32'h0};
    tbl[24] = '{1'b1, 8'h00, 1'b1, 1'b0, 5'h00, 32'h0,         1'b0, 1'b0, 4'd3, 8'h00, 32'h0};

    idle_in();
    for (int r = 0; r < 25; r++) begin
      drive(tbl[r].rst, tbl[r].src, tbl[r].reti, tbl[r].we, tbl[r].addr, tbl[r].wdata);
      tick("table");
      chk($sformatf("table_row%0d", r),
          64'({o_IRQ, o_inserv, o_inserv_id, o_pending, o_ISR_addr}),
          64'({tbl[r].irq, tbl[r].inserv, tbl[r].id, tbl[r].pend, tbl[r].isr}));
    end
    idle_in();

    // Priority order, then equal priorities falling back to index order.
    do_reset();
    cfg(5'h01, 32'hA1); cfg(5'h05, 32'hA5);
    cfg(5'h11, 32'h0000_0C04); cfg(5'h10, 32'h22); cfg(5'h13, 32'h1);
    pulse(8'h22);
    wait_irq("prio_first", 4, 4'd5);
    chk("prio_first_addr", 64'(o_ISR_addr), 64'hA5);
    serve("prio_first");
    wait_irq("prio_second", 4, 4'd1);
    serve("prio_second");
    cfg(5'h11, 32'h0);
    pulse(8'h22);
    wait_irq("tie_first", 4, 4'd1);
    serve("tie_first");
    wait_irq("tie_second", 4, 4'd5);
    serve("tie_second");

    // No nesting: a higher-priority request waits for reti.
    do_reset();
    cfg(5'h02, 32'h2222_0000); cfg(5'h06, 32'h6666_0000);
    cfg(5'h11, 32'h0000_3000); cfg(5'h10, 32'h44); cfg(5'h13, 32'h1);
    pulse(8'h04);
    wait_irq("nest_first", 4, 4'd2);
    tick("nest");
    pulse(8'h40);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin tick("nest_hold"); if (o_IRQ === 1'b1) cnt++; end
    chk("nest_blocked", 64'(cnt), 64'd0);
    chk("nest_pending6", 64'(o_pending[6]), 64'd1);
    reti = 1'b1; tick("nest_reti"); reti = 1'b0;
    chk("nest_gap", 64'(o_IRQ), 64'd0);
    tick("nest_after");
    chk("nest_after_reti", 64'({o_IRQ, o_inserv_id}), 64'({1'b1, 4'd6}));
    chk("nest_after_addr", 64'(o_ISR_addr), 64'h6666_0000);
    serve("nest_second");

    // W1C and a new edge on the same bit: the edge wins.
    do_reset();
    drive(1'b1, 8'h10, 1'b0, 1'b1, 5'h12, 32'h10);
    tick("w1c_set");
    idle_in();
    chk("w1c_vs_set", 64'(o_pending), 64'h10);
    cfg(5'h12, 32'h10);
    chk("w1c_clear", 64'(o_pending), 64'h00);

    // A new edge on the source being issued keeps its pending bit.
    cfg(5'h10, 32'h01);
    pulse(8'h01);
    cfg(5'h13, 32'h1);
    src = 8'h01;
    tick("issue_vs_set");
    src = 8'h00;
    chk("issue_vs_set", 64'({o_IRQ, o_pending[0]}), 64'({1'b1, 1'b1}));

    // A level held high produces exactly one request.
    do_reset();
    cfg(5'h10, 32'h01); cfg(5'h13, 32'h1);
    src = 8'h01;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      reti = o_inserv;
      tick("level_hold");
      if (o_IRQ === 1'b1) cnt++;
    end
    src = 8'h00; reti = 1'b0;
    for (int k = 0; k < 4; k++) begin tick("level_tail"); if (o_IRQ === 1'b1) cnt++; end
    chk("level_one_irq", 64'(cnt), 64'd1);

    // Reset during service drops everything.
    do_reset();
    cfg(5'h00, 32'hDEAD_0000); cfg(5'h10, 32'h31); cfg(5'h13, 32'h1);
    pulse(8'h01);
    wait_irq("rst_mid_irq", 4, 4'd0);
    tick("rst_mid");
    pulse(8'h30);
    chk("rst_mid_state", 64'({o_inserv, o_pending}), 64'({1'b1, 8'h30}));
    drive(1'b0, 8'h00, 1'b0, 1'b0, 5'h00, 32'h0);
    tick("rst_mid_assert");
    chk("rst_mid_cleared", 64'({o_IRQ, o_inserv, o_inserv_id, o_pending, o_ISR_addr}), 64'd0);
    idle_in();
    cnt = 0;
    for (int k = 0; k < 5; k++) begin tick("rst_mid_after"); if (o_IRQ === 1'b1) cnt++; end
    chk("rst_mid_no_irq", 64'({cnt[7:0], o_pending}), 64'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < N; i++) cfg(5'(i), $urandom);
    cfg(5'h11, $urandom); cfg(5'h10, 32'hFF); cfg(5'h13, 32'h1);
    for (int c = 0; c < 800; c++) begin
      rst  = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 2) == 0) src = src ^ (8'($urandom) & 8'($urandom));
      reti   = ($urandom_range(0, 3) == 0);
      cfg_we = ($urandom_range(0, 3) == 0);
      sel    = int'($urandom_range(0, 7));
      cfg_wdata = $urandom;
      case (sel)
        0, 1: cfg_addr = 5'($urandom_range(0, 31));
        2: cfg_addr = 5'h10;
        3: cfg_addr = 5'h11;
        4: begin cfg_addr = 5'h12; cfg_wdata = $urandom & $urandom; end
        5, 6: begin cfg_addr = 5'h13; cfg_wdata = {31'd0, ($urandom_range(0, 3) != 0)}; end
        default: cfg_addr = 5'($urandom_range(0, 7));
      endcase
      tick("random");
    end
    idle_in();
    tick("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
